// File: rtl/predecode_queue.sv
// Fetch-to-decode pre-decode stage: per-word field extraction and exception
// classification feeding an elastic circular queue of decoded records.
package predecode_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] valP;
    logic [31:0] opcode;
    logic [4:0]  rA;
    logic [4:0]  rB;
    logic [4:0]  rC;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] valC;
    logic [4:0]  btype;
    logic [4:0]  ExcCode;
    logic [31:0] erraddr;
    logic        inssl;
  } plr_d;
endpackage

// Single-word pre-decoder; one instance per fetch lane.
module predecode_lane import predecode_pkg::*; #(
  parameter bit CHECK_RSV = 1'b1
) (
  input  logic [31:0] word_i,
  input  logic [31:0] pc_i,
  input  logic        inssl_i,
  output plr_d        rec_o
);
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sh;
  logic [31:0] simm, imm;
  logic [4:0]  exc;
  logic        legal, rsv;

  assign op   = word_i[31:26];
  assign rs   = word_i[25:21];
  assign rt   = word_i[20:16];
  assign rd   = word_i[15:11];
  assign sh   = word_i[10:6];
  assign fn   = word_i[5:0];
  assign simm = {{16{word_i[15]}}, word_i[15:0]};

  // legal: opcode/funct/rt/rs is defined; rsv: a must-be-zero field is set
  always_comb begin
    legal = 1'b1;
    rsv   = 1'b0;
    exc   = 5'h0;
    imm   = '0;
    case (op)
      6'h00: begin
        case (fn)
          6'h00, 6'h02, 6'h03:                  rsv = |rs;
          6'h04, 6'h06, 6'h07:                  rsv = |sh;
          6'h08:                                rsv = |{rt, rd};
          6'h09:                                rsv = |rt;
          6'h0c:                                exc = 5'h08;
          6'h0d:                                exc = 5'h09;
          6'h10, 6'h12:                         rsv = |{rs, rt, sh};
          6'h11, 6'h13:                         rsv = |{rt, rd, sh};
          6'h18, 6'h19, 6'h1a, 6'h1b:           rsv = |{rd, sh};
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2a, 6'h2b:                         rsv = |sh;
          default:                              legal = 1'b0;
        endcase
      end
      6'h01: begin
        legal = (rt == 5'h00) || (rt == 5'h01) || (rt == 5'h10) || (rt == 5'h11);
        imm   = {simm[29:0], 2'b00};
      end
      6'h02, 6'h03: imm = {pc_i[31:28], word_i[25:0], 2'b00};
      6'h04, 6'h05: imm = {simm[29:0], 2'b00};
      6'h06, 6'h07: begin
        imm = {simm[29:0], 2'b00};
        rsv = |rt;
      end
      6'h08, 6'h09, 6'h0a, 6'h0b,
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b: imm = simm;
      6'h0c, 6'h0d, 6'h0e: imm = {16'h0, word_i[15:0]};
      6'h0f: begin
        imm = {word_i[15:0], 16'h0};
        rsv = |rs;
      end
      6'h10: begin
        case (rs)
          5'h00, 5'h04: rsv = |word_i[10:0];
          5'h10:        ;
          default:      legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    rec_o       = '0;
    rec_o.inssl = inssl_i;
    rec_o.pc    = pc_i;
    if (pc_i[1:0] != 2'b00) begin
      rec_o.erraddr = pc_i;
      rec_o.ExcCode = 5'h04;
    end else if (!legal || (CHECK_RSV && rsv)) begin
      rec_o.ExcCode = 5'h0a;
    end else begin
      rec_o.valP    = pc_i;
      rec_o.opcode  = pc_i;
      rec_o.rA      = rs;
      rec_o.rB      = rt;
      rec_o.rC      = rd;
      rec_o.shamt   = sh;
      rec_o.funct   = fn;
      rec_o.valC    = imm;
      rec_o.btype   = (op == 6'h01) ? rt : 5'h0;
      rec_o.ExcCode = exc;
    end
  end
endmodule

module predecode_queue import predecode_pkg::*; #(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8,
  parameter bit CHECK_RSV   = 1'b1,
  localparam int CNTW = $clog2(FETCH_WIDTH + 1),
  localparam int POPW = $clog2(ISSUE_WIDTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_pc,
  input  logic [CNTW-1:0]               in_cnt,
  input  logic [32*FETCH_WIDTH-1:0]     in_data,
  input  logic [FETCH_WIDTH-1:0]        in_inssl,
  output logic [ISSUE_WIDTH-1:0]        out_valid,
  output plr_d [ISSUE_WIDTH-1:0]        out_entry,
  input  logic [POPW-1:0]               out_pop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  plr_d                    mem_q [DEPTH];
  plr_d [FETCH_WIDTH-1:0]  dec;
  logic [AW-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d, nvalid;
  logic                    push;

  // Space check uses registered count only, so a same-cycle pop never frees room.
  assign in_ready = count_q <= CW'(DEPTH - FETCH_WIDTH);
  assign push     = in_valid && in_ready && !flush;

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
    predecode_lane #(.CHECK_RSV(CHECK_RSV)) u_lane (
      .word_i  (in_data[32*g +: 32]),
      .pc_i    (in_pc + 32'(4*g)),
      .inssl_i (in_inssl[g]),
      .rec_o   (dec[g])
    );
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(out_pop);
      count_d = count_q - CW'(out_pop);
      if (push) begin
        tail_d  = tail_q + AW'(in_cnt);
        count_d = count_d + CW'(in_cnt);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: reads are masked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (i < int'(in_cnt)) mem_q[tail_q + AW'(i)] <= dec[i];
      end
    end
  end

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_out
    assign out_valid[i] = count_q > CW'(i);
    assign out_entry[i] = out_valid[i] ? mem_q[head_q + AW'(i)] : '0;
  end

  assign nvalid = (count_q < CW'(ISSUE_WIDTH)) ? count_q : CW'(ISSUE_WIDTH);

  a_pop_ok : assert property (@(posedge clk) disable iff (reset) CW'(out_pop) <= nvalid)
    else $error("predecode_queue: out_pop exceeds valid entries");
endmodule

// File: tb/tb_predecode_queue.sv
// Randomized bench for predecode_queue: two instances (CHECK_RSV=1/0) against a
// queue-of-raw-words reference with a mask-table pre-decoder.
module tb_predecode_queue;
  import predecode_pkg::*;

  localparam int FW = 2, IW = 2, DEPTH = 8;
  localparam logic [31:0] RS = 32'h03E00000, RT = 32'h001F0000,
                          RD = 32'h0000F800, SH = 32'h000007C0;
  localparam logic [5:0] FNS [28] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08,
    6'h09, 6'h0c, 6'h0d, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b,
    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2a, 6'h2b, 6'h01};
  localparam logic [5:0] OPS [22] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
    6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h21, 6'h23, 6'h24,
    6'h25, 6'h28, 6'h29, 6'h2b};

  typedef struct {logic [31:0] w; logic [31:0] p; logic sl;} raw_t;

  logic clk = 1'b0;
  logic reset, flush, in_valid;
  logic [31:0] in_pc;
  logic [1:0]  in_cnt, in_inssl, out_pop;
  logic [63:0] in_data;
  logic ready_a, ready_b;
  logic [IW-1:0] valid_a, valid_b;
  plr_d [IW-1:0] ent_a, ent_b;
  int ncmp = 0, nbad = 0;
  raw_t mq[$];

  always #5 clk = ~clk;

  predecode_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH), .CHECK_RSV(1'b1)) u_dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ready_a),
    .in_pc(in_pc), .in_cnt(in_cnt), .in_data(in_data), .in_inssl(in_inssl),
    .out_valid(valid_a), .out_entry(ent_a), .out_pop(out_pop));

  predecode_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH), .CHECK_RSV(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ready_b),
    .in_pc(in_pc), .in_cnt(in_cnt), .in_data(in_data), .in_inssl(in_inssl),
    .out_valid(valid_b), .out_entry(ent_b), .out_pop(out_pop));

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference pre-decoder: legality plus a must-be-zero mask per instruction.
  function automatic plr_d ref_dec(input logic [31:0] w, input logic [31:0] p,
                                   input logic sl, input bit rsvchk);
    plr_d e; logic [31:0] zm, c; bit ok; logic [4:0] exc;
    logic [5:0] op, fn; logic [4:0] rs, rt;
    op = w[31:26]; fn = w[5:0]; rs = w[25:21]; rt = w[20:16];
    e = '0; e.inssl = sl; zm = '0; c = '0; ok = 1'b1; exc = 5'h0;
    if (p[1:0] != 2'b00) begin
      e.pc = p; e.erraddr = p; e.ExcCode = 5'h4;
      return e;
    end
    case (op) inside
      6'h00: case (fn) inside
               6'h00, 6'h02, 6'h03: zm = RS;
               6'h04, 6'h06, 6'h07: zm = SH;
               6'h08: zm = RT | RD;
               6'h09: zm = RT;
               6'h0C: exc = 5'h8;
               6'h0D: exc = 5'h9;
               6'h10, 6'h12: zm = RS | RT | SH;
               6'h11, 6'h13: zm = RT | RD | SH;
               [6'h18:6'h1B]: zm = RD | SH;
               [6'h20:6'h27], 6'h2A, 6'h2B: zm = SH;
               default: ok = 1'b0;
             endcase
      6'h01: begin
        ok = rt inside {5'h00, 5'h01, 5'h10, 5'h11};
        c = 32'($signed(w[15:0])) << 2;
      end
      6'h02, 6'h03: c = {p[31:28], w[25:0], 2'b00};
      6'h04, 6'h05: c = 32'($signed(w[15:0])) << 2;
      6'h06, 6'h07: begin c = 32'($signed(w[15:0])) << 2; zm = RT; end
      [6'h08:6'h0B], 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B:
        c = 32'($signed(w[15:0]));
      [6'h0C:6'h0E]: c = 32'(w[15:0]);
      6'h0F: begin c = 32'(w[15:0]) << 16; zm = RS; end
      6'h10: begin
        ok = rs inside {5'h00, 5'h04, 5'h10};
        if (rs != 5'h10) zm = 32'h000007FF;
      end
      default: ok = 1'b0;
    endcase
    e.pc = p;
    if (!ok || (rsvchk && (w & zm) != 0)) begin
      e.ExcCode = 5'hA;
      return e;
    end
    e.valP = p; e.opcode = p; e.rA = rs; e.rB = rt; e.rC = w[15:11];
    e.shamt = w[10:6]; e.funct = fn; e.valC = c; e.ExcCode = exc;
    if (op == 6'h01) e.btype = rt;
    return e;
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] r; int unsigned k;
    r = $urandom;
    if ($urandom_range(0, 1) != 0) r[25:21] = '0;
    if ($urandom_range(0, 1) != 0) r[20:16] = '0;
    if ($urandom_range(0, 1) != 0) r[15:11] = '0;
    if ($urandom_range(0, 1) != 0) r[10:6]  = '0;
    if ($urandom_range(0, 2) == 0) r[10:0]  = '0;
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2: begin r[31:26] = 6'h00; r[5:0] = FNS[$urandom_range(0, 27)]; end
      3: begin
        r[31:26] = 6'h01;
        case ($urandom_range(0, 4))
          0: r[20:16] = 5'h00; 1: r[20:16] = 5'h01; 2: r[20:16] = 5'h10;
          3: r[20:16] = 5'h11; default: r[20:16] = 5'h03;
        endcase
      end
      4: begin
        r[31:26] = 6'h10;
        case ($urandom_range(0, 3))
          0: r[25:21] = 5'h00; 1: r[25:21] = 5'h04; 2: r[25:21] = 5'h10;
          default: r[25:21] = 5'h02;
        endcase
      end
      5: r = 32'h42000018;
      6: r[31:26] = 6'($urandom_range(0, 63));
      default: r[31:26] = OPS[$urandom_range(0, 21)];
    endcase
    return r;
  endfunction

  task automatic check_all(input string ph);
    plr_d xa, xb; bit v;
    chk({ph, ".rdy_a"}, 256'(ready_a), 256'((DEPTH - mq.size()) >= FW));
    chk({ph, ".rdy_b"}, 256'(ready_b), 256'((DEPTH - mq.size()) >= FW));
    for (int i = 0; i < IW; i++) begin
      v = i < mq.size();
      xa = '0; xb = '0;
      if (v) begin
        xa = ref_dec(mq[i].w, mq[i].p, mq[i].sl, 1'b1);
        xb = ref_dec(mq[i].w, mq[i].p, mq[i].sl, 1'b0);
      end
      chk($sformatf("%s.vld_a%0d", ph, i), 256'(valid_a[i]), 256'(v));
      chk($sformatf("%s.vld_b%0d", ph, i), 256'(valid_b[i]), 256'(v));
      chk($sformatf("%s.ent_a%0d", ph, i), 256'(ent_a[i]), 256'(xa));
      chk($sformatf("%s.ent_b%0d", ph, i), 256'(ent_b[i]), 256'(xb));
    end
  endtask

  // Called #1 after a rising edge; drives one cycle, advances the model, checks.
  task automatic cyc(input bit v, input logic [31:0] pc, input int cnt,
                     input logic [31:0] w0, input logic [31:0] w1, input logic [1:0] sl,
                     input int pop, input bit fl, input string ph);
    bit rdy;
    rdy = (DEPTH - mq.size()) >= FW;
    in_valid = v; in_pc = pc; in_cnt = 2'(cnt); in_data = {w1, w0};
    in_inssl = sl; out_pop = 2'(pop); flush = fl;
    if (fl) mq.delete();
    else begin
      for (int k = 0; k < pop; k++) void'(mq.pop_front());
      if (v && rdy) begin
        mq.push_back('{w0, pc, sl[0]});
        if (cnt > 1) mq.push_back('{w1, pc + 32'd4, sl[1]});
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_pop = 2'd0; flush = 1'b0;
    check_all(ph);
  endtask

  function automatic int avail();
    return (mq.size() < IW) ? mq.size() : IW;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] nxt_push, nxt_pop, pc;
    int pushed, guard, pop, cnt;
    bit v, rdy;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_cnt = '0;
    in_data = '0; in_inssl = '0; out_pop = '0;
    #1 reset = 1'b1;
    #2;
    chk("rst_valid", 256'(valid_a), 256'(0));
    chk("rst_ready", 256'(ready_a), 256'(1));
    chk("rst_entry", 256'(ent_a), 256'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_all("idle");

    // Reset, single push
    cyc(1, 32'hBFC00000, 2, 32'h24010005, 32'h3C02ABCD, 2'b00, 0, 0, "t1");
    chk("t1_valid", 256'(valid_a), 256'(2'b11));
    chk("t1_valC0", 256'(ent_a[0].valC), 256'(32'h5));
    chk("t1_rB0", 256'(ent_a[0].rB), 256'(1));
    chk("t1_valC1", 256'(ent_a[1].valC), 256'(32'hABCD0000));
    cyc(0, 0, 1, 0, 0, 0, 2, 0, "t1_pop");

    // Misaligned PC
    cyc(1, 32'hBFC00002, 1, 32'h24010005, 0, 2'b01, 0, 0, "t2");
    chk("t2_exc", 256'(ent_a[0].ExcCode), 256'(5'h4));
    chk("t2_erraddr", 256'(ent_a[0].erraddr), 256'(32'hBFC00002));
    chk("t2_opcode", 256'(ent_a[0].opcode), 256'(0));
    chk("t2_inssl", 256'(ent_a[0].inssl), 256'(1));
    cyc(0, 0, 1, 0, 0, 0, 1, 0, "t2_pop");

    // Reserved fields, SYSCALL/BREAK, ERET
    cyc(1, 32'h1000, 2, 32'h00430821, 32'h00430861, 0, 0, 0, "t3");
    chk("t3_a0_exc", 256'(ent_a[0].ExcCode), 256'(0));
    chk("t3_a1_exc", 256'(ent_a[1].ExcCode), 256'(5'hA));
    chk("t3_b1_exc", 256'(ent_b[1].ExcCode), 256'(0));
    chk("t3_b1_shamt", 256'(ent_b[1].shamt), 256'(1));
    cyc(1, 32'h2000, 2, 32'h0000000C, 32'h0000000D, 0, 2, 0, "t3_sys");
    chk("t3_syscall", 256'(ent_a[0].ExcCode), 256'(5'h8));
    chk("t3_break", 256'(ent_a[1].ExcCode), 256'(5'h9));
    cyc(1, 32'h3000, 1, 32'h42000018, 0, 0, 2, 0, "t3_eret");
    chk("t3_eret_vld", 256'(valid_a), 256'(2'b01));
    chk("t3_eret_exc", 256'(ent_a[0].ExcCode), 256'(0));
    chk("t3_eret_pc", 256'(ent_a[0].valP), 256'(32'h3000));
    cyc(0, 0, 1, 0, 0, 0, 1, 0, "t3_pop");

    // Fill to full, then pops, then flush with push and pop at count 5
    for (int g = 0; g < 4; g++) begin
      cyc(1, 32'h100 + 32'(8*g), 2, 32'h24000000 | 32'(2*g), 32'h24000001 | 32'(2*g),
          2'b10, 0, 0, "t4_fill");
      if (g == 2) chk("t4_rdy_at6", 256'(ready_a), 256'(1));
    end
    chk("t4_rdy_full", 256'(ready_a), 256'(0));
    cyc(1, 32'h900, 2, 32'h24000100, 32'h24000101, 0, 0, 0, "t4_ignored");
    chk("t4_rdy_still", 256'(ready_a), 256'(0));
    cyc(1, 32'h908, 2, 32'h24000102, 32'h24000103, 0, 2, 0, "t4_pop_nopush");
    chk("t4_rdy_after_pop", 256'(ready_a), 256'(1));
    chk("t4_head_pc", 256'(ent_a[0].pc), 256'(32'h108));
    cyc(0, 0, 1, 0, 0, 0, 1, 0, "t4_to5");
    cyc(1, 32'hA00, 2, 32'h24000200, 32'h24000201, 0, 1, 1, "t5_flush");
    chk("t5_vld", 256'(valid_a), 256'(0));
    chk("t5_rdy", 256'(ready_a), 256'(1));

    // Wrap and order: 40 sequential PCs with random pops
    nxt_push = 32'h00400000; nxt_pop = 32'h00400000; pushed = 0; guard = 0;
    while ((pushed < 40 || mq.size() > 0) && guard < 500) begin
      pop = $urandom_range(0, avail());
      cnt = (40 - pushed >= 2) ? $urandom_range(1, 2) : 1;
      v = (pushed < 40) && ($urandom_range(0, 3) != 0);
      rdy = (DEPTH - mq.size()) >= FW;
      for (int j = 0; j < pop; j++) begin
        chk("wrap_order", 256'(ent_a[j].pc), 256'(nxt_pop));
        nxt_pop += 32'd4;
      end
      cyc(v, nxt_push, cnt, 32'h24000000 | 32'(pushed), 32'h24000000 | 32'(pushed + 1),
          2'($urandom_range(0, 3)), pop, 0, "wrap");
      if (v && rdy) begin
        nxt_push += 32'(4 * cnt);
        pushed += cnt;
      end
      guard++;
    end
    chk("wrap_drained", 256'(nxt_pop), 256'(32'h00400000 + 32'd160));

    // Random traffic with flushes and misaligned groups
    for (int n = 0; n < 400; n++) begin
      pc = $urandom;
      if ($urandom_range(0, 7) != 0) pc[1:0] = 2'b00;
      cyc($urandom_range(0, 3) != 0, pc, $urandom_range(1, 2), rnd_word(), rnd_word(),
          2'($urandom_range(0, 3)), $urandom_range(0, avail()),
          $urandom_range(0, 31) == 0, "rand");
    end

    // Reset mid-operation clears immediately
    cyc(1, 32'h5000, 2, 32'h24000001, 32'h24000002, 0, 0, 0, "pre_rst");
    reset = 1'b1;
    #1;
    chk("midrst_vld", 256'(valid_a), 256'(0));
    chk("midrst_ent", 256'(ent_a), 256'(0));
    chk("midrst_rdy", 256'(ready_a), 256'(1));
    mq.delete();
    @(posedge clk); #1 reset = 1'b0;
    check_all("post_rst");
    cyc(1, 32'h6000, 2, 32'h3C021234, 32'h0000000C, 2'b11, 0, 0, "post_rst_push");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
